// File: rtl/input4_stim_gen.sv
// rtl/input4_stim_gen.sv - four-channel periodic toggle stimulus generator for a 4-input OR stage
module input4_stim_gen #(
   parameter int P_AA    = 60,
   parameter int P_BB    = 100,
   parameter int P_CC    = 150,
   parameter int P_DD    = 200,
   parameter int RUN_LEN = 1000,
   parameter int CW      = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic stop,
   output logic aa,
   output logic bb,
   output logic cc,
   output logic dd,
   output logic busy,
   output logic done
);

   // Last count value of each channel; the toggle fires on the edge that wraps it.
   localparam logic [CW-1:0] LP_AA_LAST  = CW'(P_AA - 1);
   localparam logic [CW-1:0] LP_BB_LAST  = CW'(P_BB - 1);
   localparam logic [CW-1:0] LP_CC_LAST  = CW'(P_CC - 1);
   localparam logic [CW-1:0] LP_DD_LAST  = CW'(P_DD - 1);
   localparam logic [CW-1:0] LP_RUN_LEN  = CW'(RUN_LEN);
   localparam logic [CW-1:0] LP_ONE      = CW'(1);
   localparam logic [CW-1:0] LP_ZERO     = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;

   // Run edge counter n and the per-channel phase counters.
   logic [CW-1:0] r_n;
   logic [CW-1:0] r_cnt_aa;
   logic [CW-1:0] r_cnt_bb;
   logic [CW-1:0] r_cnt_cc;
   logic [CW-1:0] r_cnt_dd;

   logic [CW-1:0] w_n_next;
   logic [CW-1:0] w_cnt_aa_next;
   logic [CW-1:0] w_cnt_bb_next;
   logic [CW-1:0] w_cnt_cc_next;
   logic [CW-1:0] w_cnt_dd_next;

   // Registered outputs.
   logic          r_aa;
   logic          r_bb;
   logic          r_cc;
   logic          r_dd;
   logic          r_busy;
   logic          r_done;

   logic          w_aa_next;
   logic          w_bb_next;
   logic          w_cc_next;
   logic          w_dd_next;
   logic          w_busy_next;
   logic          w_done_next;

   // Per-channel wrap detection and the run counter value after this edge.
   logic          w_hit_aa;
   logic          w_hit_bb;
   logic          w_hit_cc;
   logic          w_hit_dd;
   logic [CW-1:0] w_n_inc;
   logic          w_last_edge;

   assign w_hit_aa    = (r_cnt_aa == LP_AA_LAST);
   assign w_hit_bb    = (r_cnt_bb == LP_BB_LAST);
   assign w_hit_cc    = (r_cnt_cc == LP_CC_LAST);
   assign w_hit_dd    = (r_cnt_dd == LP_DD_LAST);
   assign w_n_inc     = r_n + LP_ONE;
   assign w_last_edge = (w_n_inc == LP_RUN_LEN);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state, counter and output decisions; outputs are registered below.
   always_comb begin
      w_state_next  = r_state;
      w_n_next      = r_n;
      w_cnt_aa_next = r_cnt_aa;
      w_cnt_bb_next = r_cnt_bb;
      w_cnt_cc_next = r_cnt_cc;
      w_cnt_dd_next = r_cnt_dd;
      w_aa_next     = r_aa;
      w_bb_next     = r_bb;
      w_cc_next     = r_cc;
      w_dd_next     = r_dd;
      w_busy_next   = r_busy;
      w_done_next   = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_aa_next   = 1'b0;
            w_bb_next   = 1'b0;
            w_cc_next   = 1'b0;
            w_dd_next   = 1'b0;
            w_busy_next = 1'b0;
            // stop dominates start so a simultaneous request never launches a run
            if (start && !stop) begin
               w_state_next  = S_RUN;
               w_n_next      = LP_ZERO;
               w_cnt_aa_next = LP_ZERO;
               w_cnt_bb_next = LP_ZERO;
               w_cnt_cc_next = LP_ZERO;
               w_cnt_dd_next = LP_ZERO;
               w_busy_next   = 1'b1;
            end
         end

         S_RUN: begin
            if (stop) begin
               // abort: back to a quiet line set with no completion pulse
               w_state_next  = S_IDLE;
               w_n_next      = LP_ZERO;
               w_cnt_aa_next = LP_ZERO;
               w_cnt_bb_next = LP_ZERO;
               w_cnt_cc_next = LP_ZERO;
               w_cnt_dd_next = LP_ZERO;
               w_aa_next     = 1'b0;
               w_bb_next     = 1'b0;
               w_cc_next     = 1'b0;
               w_dd_next     = 1'b0;
               w_busy_next   = 1'b0;
            end else begin
               w_n_next      = w_n_inc;
               // each channel wraps its own counter, so phases never drift
               w_cnt_aa_next = w_hit_aa ? LP_ZERO : (r_cnt_aa + LP_ONE);
               w_cnt_bb_next = w_hit_bb ? LP_ZERO : (r_cnt_bb + LP_ONE);
               w_cnt_cc_next = w_hit_cc ? LP_ZERO : (r_cnt_cc + LP_ONE);
               w_cnt_dd_next = w_hit_dd ? LP_ZERO : (r_cnt_dd + LP_ONE);
               w_aa_next     = r_aa ^ w_hit_aa;
               w_bb_next     = r_bb ^ w_hit_bb;
               w_cc_next     = r_cc ^ w_hit_cc;
               w_dd_next     = r_dd ^ w_hit_dd;
               // toggles due on the final edge are still applied above
               if (w_last_edge) begin
                  w_state_next = S_DONE;
                  w_busy_next  = 1'b0;
                  w_done_next  = 1'b1;
               end
            end
         end

         S_DONE: begin
            // single-cycle state: lines held through it, cleared on exit
            w_state_next = S_IDLE;
            w_aa_next    = 1'b0;
            w_bb_next    = 1'b0;
            w_cc_next    = 1'b0;
            w_dd_next    = 1'b0;
            w_busy_next  = 1'b0;
         end

         default: begin
            w_state_next = S_IDLE;
            w_aa_next    = 1'b0;
            w_bb_next    = 1'b0;
            w_cc_next    = 1'b0;
            w_dd_next    = 1'b0;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n      <= '0;
         r_cnt_aa <= '0;
         r_cnt_bb <= '0;
         r_cnt_cc <= '0;
         r_cnt_dd <= '0;
      end else begin
         r_n      <= w_n_next;
         r_cnt_aa <= w_cnt_aa_next;
         r_cnt_bb <= w_cnt_bb_next;
         r_cnt_cc <= w_cnt_cc_next;
         r_cnt_dd <= w_cnt_dd_next;
      end
   end

   // Output registers; every port is a flop output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aa   <= 1'b0;
         r_bb   <= 1'b0;
         r_cc   <= 1'b0;
         r_dd   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_aa   <= w_aa_next;
         r_bb   <= w_bb_next;
         r_cc   <= w_cc_next;
         r_dd   <= w_dd_next;
         r_busy <= w_busy_next;
         r_done <= w_done_next;
      end
   end

   assign aa   = r_aa;
   assign bb   = r_bb;
   assign cc   = r_cc;
   assign dd   = r_dd;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_input4_stim_gen.sv
// tb/tb_input4_stim_gen.sv - self-checking bench for input4_stim_gen
module tb_input4_stim_gen;

   localparam int P_AA    = 60;
   localparam int P_BB    = 100;
   localparam int P_CC    = 150;
   localparam int P_DD    = 200;
   localparam int RUN_LEN = 1000;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic clk;
   logic rst;
   logic start;
   logic stop;
   logic aa, bb, cc, dd, busy, done;

   logic start2;
   logic stop2;
   logic aa2, bb2, cc2, dd2, busy2, done2;

   int checks;
   int failures;

   int m_state;
   int m_n;

   input4_stim_gen #(
      .P_AA(P_AA), .P_BB(P_BB), .P_CC(P_CC), .P_DD(P_DD),
      .RUN_LEN(RUN_LEN), .CW(16)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .aa(aa), .bb(bb), .cc(cc), .dd(dd), .busy(busy), .done(done)
   );

   input4_stim_gen #(
      .P_AA(2), .P_BB(2), .P_CC(3), .P_DD(4), .RUN_LEN(4), .CW(16)
   ) u_small (
      .clk(clk), .rst(rst), .start(start2), .stop(stop2),
      .aa(aa2), .bb(bb2), .cc(cc2), .dd(dd2), .busy(busy2), .done(done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Channel level after n run edges: number of completed periods, taken mod 2.
   function automatic logic lvl(input int n, input int p);
      return ((n / p) % 2) == 1;
   endfunction

   function automatic logic [5:0] model_out();
      case (m_state)
         M_RUN:  return {lvl(m_n, P_AA), lvl(m_n, P_BB), lvl(m_n, P_CC), lvl(m_n, P_DD), 1'b1, 1'b0};
         M_DONE: return {lvl(RUN_LEN, P_AA), lvl(RUN_LEN, P_BB), lvl(RUN_LEN, P_CC), lvl(RUN_LEN, P_DD), 1'b0, 1'b1};
         default: return 6'b000000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock of the main instance: drive, clock, advance the model, compare.
   task automatic step(input logic s, input logic p, input string tag);
      start = s;
      stop  = p;
      @(posedge clk);
      #1;
      case (m_state)
         M_IDLE: if (s && !p) begin m_state = M_RUN; m_n = 0; end
         M_RUN: begin
            if (p) begin
               m_state = M_IDLE;
               m_n = 0;
            end else begin
               m_n++;
               if (m_n == RUN_LEN) m_state = M_DONE;
            end
         end
         default: begin m_state = M_IDLE; m_n = 0; end
      endcase
      check($sformatf("%s n=%0d", tag, m_n), {aa, bb, cc, dd, busy, done}, model_out());
   endtask

   task automatic step_small(input logic s, input logic [5:0] exp, input string tag);
      start2 = s;
      stop2  = 1'b0;
      @(posedge clk);
      #1;
      check(tag, {aa2, bb2, cc2, dd2, busy2, done2}, exp);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_state  = M_IDLE;
      m_n      = 0;
      rst      = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      start2   = 1'b0;
      stop2    = 1'b0;

      // reset state
      @(posedge clk);
      #1;
      check("reset", {aa, bb, cc, dd, busy, done}, 6'b000000);
      check("reset_small", {aa2, bb2, cc2, dd2, busy2, done2}, 6'b000000);
      rst = 1'b0;
      step(1'b0, 1'b0, "idle");

      // start and stop together: stays idle
      step(1'b1, 1'b1, "start_stop");
      step(1'b0, 1'b0, "after_start_stop");

      // full run with start held high: no relaunch until DONE has passed
      for (int i = 0; i < RUN_LEN + 3; i++) step(1'b1, 1'b0, "run_held");
      // a new run began on the last step; take it to n=250 then abort
      for (int i = 0; i < 250; i++) step(1'b0, 1'b0, "run2");
      step(1'b0, 1'b1, "stop_250");
      step(1'b0, 1'b0, "after_stop");
      step(1'b1, 1'b0, "restart");
      for (int i = 0; i < 130; i++) step(($urandom % 2) == 1, 1'b0, "restart_run");
      step(1'b0, 1'b1, "stop_restart");

      // randomized aborts with start noise while running
      for (int r = 0; r < 4; r++) begin
         int gap;
         int stop_at;
         gap     = $urandom_range(0, 3);
         stop_at = $urandom_range(1, RUN_LEN - 2);
         for (int g = 0; g < gap; g++) step(1'b0, ($urandom % 2) == 1, "gap");
         step(1'b1, 1'b0, "rand_start");
         for (int k = 0; k < stop_at; k++) step(($urandom % 2) == 1, 1'b0, "rand_run");
         step(1'b0, 1'b1, "rand_stop");
      end

      // asynchronous reset at n=430, between clock edges
      step(1'b1, 1'b0, "rst_run_start");
      for (int i = 0; i < 430; i++) step(1'b0, 1'b0, "rst_run");
      #3;
      rst = 1'b1;
      m_state = M_IDLE;
      m_n = 0;
      #1;
      check("async_rst", {aa, bb, cc, dd, busy, done}, 6'b000000);
      @(posedge clk);
      #1;
      check("rst_held", {aa, bb, cc, dd, busy, done}, 6'b000000);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "post_rst_idle");
      step(1'b1, 1'b0, "post_rst_start");
      for (int i = 0; i < 61; i++) step(1'b0, 1'b0, "post_rst_run");
      step(1'b0, 1'b1, "post_rst_stop");

      // short-parameter instance: aa/bb toggle together at n=2 and n=4
      step_small(1'b1, 6'b000010, "small_n0");
      step_small(1'b0, 6'b000010, "small_n1");
      step_small(1'b0, 6'b110010, "small_n2");
      step_small(1'b0, 6'b111010, "small_n3");
      step_small(1'b0, 6'b001101, "small_n4_done");
      step_small(1'b0, 6'b000000, "small_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
